// File: rtl/corr_pkg.sv
// Shared geometry, widths and FSM encoding for the window correlator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package corr_pkg;

    localparam int TW     = 8;
    localparam int TH     = 8;
    localparam int PIX_W  = 8;
    localparam int N      = TW * TH;
    localparam int TIDX_W = $clog2(N);
    // The worst case N*(2^PIX_W - 1) fits exactly, so the accumulator never wraps.
    localparam int SAD_W  = PIX_W + TIDX_W;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        DRAIN  = 3'd2,
        DONE   = 3'd3,
        REJECT = 3'd4
    } state_e;

    // Unsigned absolute difference of two pixels.
    function automatic logic [PIX_W-1:0] abs_diff(input logic [PIX_W-1:0] a,
                                                  input logic [PIX_W-1:0] b);
        logic [PIX_W-1:0] r;
        if (a >= b) r = a - b;
        else        r = b - a;
        return r;
    endfunction

endpackage

// File: rtl/corr_tpl_ram.sv
// Template store: N x PIX_W registers, synchronous write, asynchronous read.
// Latency: write visible the cycle after the write edge; read is combinational.
// Backpressure: none; the owner gates the write strobe.
module corr_tpl_ram
    import corr_pkg::*;
(
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [TIDX_W-1:0] waddr_i,
    input  logic [PIX_W-1:0]  wdata_i,
    input  logic [TIDX_W-1:0] raddr_i,
    output logic [PIX_W-1:0]  rdata_o
);

    // Template contents are intentionally not reset.
    logic [PIX_W-1:0] mem_q [N];

    // Write port: one pixel per edge when enabled.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/window_correlator.sv
// SAD between the stored template and one TW x TH frame window read from the frame buffer.
// Latency: N+RD_LAT+1 edges from an accepted start to oCorrFinished; an out-of-bounds start answers after 1 edge.
// Backpressure: none; frame data must return after exactly RD_LAT cycles, starts while busy are dropped.
module window_correlator
    import corr_pkg::*;
#(
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int ADDR_W = 19,
    parameter int RD_LAT = 2
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              iStart,
    input  logic [12:0]       iX,
    input  logic [12:0]       iY,
    input  logic              iTplWe,
    input  logic [TIDX_W-1:0] iTplAddr,
    input  logic [PIX_W-1:0]  iTplData,
    output logic              oRdReq,
    output logic [ADDR_W-1:0] oRdAddr,
    input  logic [PIX_W-1:0]  iRdData,
    output logic              oBusy,
    output logic [SAD_W-1:0]  oCorr,
    output logic              oCorrFinished
);

    localparam int COL_W = $clog2(TW);
    // Moving from the last column of one window row to the first column of the next.
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W - TW + 1);
    localparam logic [COL_W-1:0]  LAST_COL = COL_W'(TW - 1);
    localparam logic [TIDX_W-1:0] LAST_IDX = TIDX_W'(N - 1);

    state_e              state_q, state_d;
    logic                rd_req_q, rd_req_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [TIDX_W-1:0]   idx_q, idx_d;
    logic [SAD_W-1:0]    acc_q, acc_d;
    logic [SAD_W-1:0]    corr_q, corr_d;
    logic                fin_q, fin_d;

    // Delay line carrying (valid, template index) alongside each outstanding read.
    logic [RD_LAT-1:0]   dly_vld_q;
    logic [TIDX_W-1:0]   dly_idx_q [RD_LAT];

    logic                in_bounds;
    logic                accept;
    logic                tpl_we;
    logic [PIX_W-1:0]    tpl_pix;
    logic [ADDR_W-1:0]   start_addr;
    logic                ret_vld;
    logic [TIDX_W-1:0]   ret_idx;

    assign in_bounds  = ((int'(iX) + TW) <= IMG_W) && ((int'(iY) + TH) <= IMG_H);
    assign accept     = (state_q == IDLE) && iStart && in_bounds;
    assign start_addr = ADDR_W'(int'(iY) * IMG_W + int'(iX));

    // Writes only land while idle; a write in the start cycle is seen by that correlation.
    assign tpl_we     = iTplWe && (state_q == IDLE);

    assign ret_vld    = dly_vld_q[RD_LAT-1];
    assign ret_idx    = dly_idx_q[RD_LAT-1];

    corr_tpl_ram u_tpl_ram (
        .clk_i   (iCLK),
        .we_i    (tpl_we),
        .waddr_i (iTplAddr),
        .wdata_i (iTplData),
        .raddr_i (ret_idx),
        .rdata_o (tpl_pix)
    );

    // Accumulator next state: cleared on accept, one abs-diff term per returning pixel.
    always_comb begin
        acc_d = acc_q;
        if (accept) begin
            acc_d = '0;
        end else if (ret_vld) begin
            acc_d = acc_q + SAD_W'(abs_diff(iRdData, tpl_pix));
        end
    end

    // FSM next state, read address generation and result/pulse outputs.
    always_comb begin
        state_d   = state_q;
        rd_req_d  = rd_req_q;
        rd_addr_d = rd_addr_q;
        col_d     = col_q;
        idx_d     = idx_q;
        corr_d    = corr_q;
        fin_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (iStart) begin
                    if (in_bounds) begin
                        state_d   = ISSUE;
                        rd_req_d  = 1'b1;
                        rd_addr_d = start_addr;
                        col_d     = '0;
                        idx_d     = '0;
                    end else begin
                        state_d   = REJECT;
                        corr_d    = '1;
                        fin_d     = 1'b1;
                    end
                end
            end
            ISSUE: begin
                // The current cycle presents read idx_q; stop after the last one.
                if (idx_q == LAST_IDX) begin
                    state_d  = DRAIN;
                    rd_req_d = 1'b0;
                end else begin
                    idx_d = idx_q + 1'b1;
                    if (col_q == LAST_COL) begin
                        col_d     = '0;
                        rd_addr_d = rd_addr_q + ROW_STEP;
                    end else begin
                        col_d     = col_q + 1'b1;
                        rd_addr_d = rd_addr_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                // Publish the sum including the final term on the edge that accumulates it.
                if (ret_vld && (ret_idx == LAST_IDX)) begin
                    state_d = DONE;
                    corr_d  = acc_d;
                    fin_d   = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            REJECT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control and datapath registers; reset aborts any correlation in flight.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q   <= IDLE;
            rd_req_q  <= 1'b0;
            rd_addr_q <= '0;
            col_q     <= '0;
            idx_q     <= '0;
            acc_q     <= '0;
            corr_q    <= '0;
            fin_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_req_q  <= rd_req_d;
            rd_addr_q <= rd_addr_d;
            col_q     <= col_d;
            idx_q     <= idx_d;
            acc_q     <= acc_d;
            corr_q    <= corr_d;
            fin_q     <= fin_d;
        end
    end

    // Read-latency delay line: stage RD_LAT-1 lines up with iRdData for that request.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            dly_vld_q <= '0;
            for (int j = 0; j < RD_LAT; j++) begin
                dly_idx_q[j] <= '0;
            end
        end else begin
            dly_vld_q[0] <= rd_req_q;
            dly_idx_q[0] <= idx_q;
            for (int j = 1; j < RD_LAT; j++) begin
                dly_vld_q[j] <= dly_vld_q[j-1];
                dly_idx_q[j] <= dly_idx_q[j-1];
            end
        end
    end

    assign oRdReq        = rd_req_q;
    assign oRdAddr       = rd_addr_q;
    assign oBusy         = (state_q != IDLE);
    assign oCorr         = corr_q;
    assign oCorrFinished = fin_q;

endmodule

// File: tb/tb_window_correlator.sv
// Self-checking bench for window_correlator with a fixed-latency frame-buffer model.
// Latency: checks the N+RD_LAT+1 edge completion and the 1 edge reject.
// Backpressure: none on the DUT; starts and template writes while busy are exercised.
module tb_window_correlator;

    localparam int TW     = 8;
    localparam int TH     = 8;
    localparam int N      = TW * TH;
    localparam int IMG_W  = 640;
    localparam int IMG_H  = 480;
    localparam int RD_LAT = 2;
    localparam int LAT    = N + RD_LAT + 1;

    logic        iCLK = 1'b0;
    logic        iRST_N = 1'b0;
    logic        iStart = 1'b0;
    logic [12:0] iX = '0;
    logic [12:0] iY = '0;
    logic        iTplWe = 1'b0;
    logic [5:0]  iTplAddr = '0;
    logic [7:0]  iTplData = '0;
    logic        oRdReq;
    logic [18:0] oRdAddr;
    logic [7:0]  iRdData;
    logic        oBusy;
    logic [13:0] oCorr;
    logic        oCorrFinished;

    int n_checks = 0;
    int n_fail   = 0;

    int frame_mode  = 0;
    int frame_const = 0;
    int frame_seed  = 0;
    int tpl_m [N];
    int pulse_cnt = 0;
    int rd_q [$];
    logic [7:0] pipe [RD_LAT];

    window_correlator #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (19),
        .RD_LAT (RD_LAT)
    ) dut (
        .iCLK          (iCLK),
        .iRST_N        (iRST_N),
        .iStart        (iStart),
        .iX            (iX),
        .iY            (iY),
        .iTplWe        (iTplWe),
        .iTplAddr      (iTplAddr),
        .iTplData      (iTplData),
        .oRdReq        (oRdReq),
        .oRdAddr       (oRdAddr),
        .iRdData       (iRdData),
        .oBusy         (oBusy),
        .oCorr         (oCorr),
        .oCorrFinished (oCorrFinished)
    );

    always #5 iCLK = ~iCLK;

    function automatic int frame_pix(input int addr);
        if (frame_mode == 0) return frame_const;
        return ((addr * 7) ^ (addr >> 5) ^ frame_seed) & 255;
    endfunction

    // Frame buffer: request sampled at an edge, data shown RD_LAT cycles later.
    always @(posedge iCLK) begin
        for (int j = RD_LAT - 1; j > 0; j--) pipe[j] <= pipe[j-1];
        pipe[0] <= oRdReq ? 8'(frame_pix(int'(oRdAddr))) : 8'h00;
    end
    assign iRdData = pipe[RD_LAT-1];

    // Bus monitor: log read addresses and completion pulses.
    always @(negedge iCLK) begin
        if (iRST_N && oRdReq) rd_q.push_back(int'(oRdAddr));
        if (oCorrFinished) pulse_cnt++;
    end

    function automatic int model_sad(input int x, input int y);
        int s = 0;
        for (int r = 0; r < TH; r++) begin
            for (int c = 0; c < TW; c++) begin
                int p = frame_pix((y + r) * IMG_W + x + c);
                int t = tpl_m[r * TW + c];
                s += (p > t) ? (p - t) : (t - p);
            end
        end
        return s;
    endfunction

    function automatic int addr_errors(input int x, input int y);
        int bad = 0;
        if (rd_q.size() != N) return N;
        for (int k = 0; k < N; k++)
            if (rd_q[k] != (y + k / TW) * IMG_W + x + k % TW) bad++;
        return bad;
    endfunction

    task automatic load_tpl();
        for (int i = 0; i < N; i++) begin
            @(negedge iCLK);
            iTplWe = 1'b1; iTplAddr = 6'(i); iTplData = 8'(tpl_m[i]);
        end
        @(negedge iCLK);
        iTplWe = 1'b0;
    endtask

    // Start a correlation (optionally with a template write in the same cycle)
    // and wait for the pulse; edges counts posedges from the start edge inclusive.
    task automatic run_corr(input int x, input int y, input bit we, input int waddr, input int wdata,
                            output int edges, output logic [13:0] corr, output bit ok);
        rd_q.delete();
        @(negedge iCLK);
        iStart = 1'b1; iX = 13'(x); iY = 13'(y);
        iTplWe = we; iTplAddr = 6'(waddr); iTplData = 8'(wdata);
        @(negedge iCLK);
        iStart = 1'b0; iTplWe = 1'b0;
        iX = 13'($urandom); iY = 13'($urandom);
        edges = 1; ok = 1'b0;
        while (edges < 300) begin
            if (oCorrFinished) begin ok = 1'b1; break; end
            @(negedge iCLK);
            edges++;
        end
        corr = oCorr;
    endtask

    task automatic test_reset();
        @(negedge iCLK);
        n_checks++;
        if ({oRdReq, oRdAddr, oBusy, oCorr, oCorrFinished} !== '0) begin
            n_fail++; $display("FAIL in_reset: outputs=%h required 0", {oRdReq, oRdAddr, oBusy, oCorr, oCorrFinished});
        end
        repeat (2) @(negedge iCLK);
        iRST_N = 1'b1;
        @(negedge iCLK);
        n_checks++; if (oRdReq !== 1'b0) begin n_fail++; $display("FAIL rst_rdreq: got %b required 0", oRdReq); end
        n_checks++; if (oRdAddr !== '0) begin n_fail++; $display("FAIL rst_rdaddr: got %0d required 0", oRdAddr); end
        n_checks++; if (oBusy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b required 0", oBusy); end
        n_checks++; if (oCorr !== '0) begin n_fail++; $display("FAIL rst_corr: got %0d required 0", oCorr); end
        n_checks++; if (oCorrFinished !== 1'b0) begin n_fail++; $display("FAIL rst_fin: got %b required 0", oCorrFinished); end
    endtask

    task automatic test_const();
        int edges; logic [13:0] corr; bit ok; int first, last;
        frame_mode = 0; frame_const = 10;
        for (int i = 0; i < N; i++) tpl_m[i] = 0;
        load_tpl();
        run_corr(0, 0, 1'b0, 0, 0, edges, corr, ok);
        first = (rd_q.size() > 0) ? rd_q[0] : -1;
        last  = (rd_q.size() > 0) ? rd_q[rd_q.size()-1] : -1;
        n_checks++; if (!ok || edges != LAT) begin n_fail++; $display("FAIL const_latency: got %0d edges required %0d", edges, LAT); end
        n_checks++; if (corr !== 14'd640) begin n_fail++; $display("FAIL const_corr: got %0d required 640", corr); end
        n_checks++; if (oBusy !== 1'b1) begin n_fail++; $display("FAIL const_busy_done: got %b required 1", oBusy); end
        n_checks++; if (rd_q.size() != N) begin n_fail++; $display("FAIL const_nreads: got %0d required %0d", rd_q.size(), N); end
        n_checks++; if (first != 0) begin n_fail++; $display("FAIL const_first_addr: got %0d required 0", first); end
        n_checks++; if (last != 4487) begin n_fail++; $display("FAIL const_last_addr: got %0d required 4487", last); end
        n_checks++; if (addr_errors(0, 0) != 0) begin n_fail++; $display("FAIL const_addr_seq: %0d wrong addresses, required 0", addr_errors(0, 0)); end
        @(negedge iCLK);
        n_checks++; if ({oBusy, oCorrFinished} !== 2'b00) begin n_fail++; $display("FAIL const_after: busy,fin=%b required 00", {oBusy, oCorrFinished}); end
        n_checks++; if (oCorr !== 14'd640) begin n_fail++; $display("FAIL const_hold: got %0d required 640", oCorr); end
    endtask

    task automatic test_match();
        int edges; logic [13:0] corr; bit ok; int first, last;
        frame_mode = 1; frame_seed = int'($urandom_range(0, 255));
        for (int r = 0; r < TH; r++)
            for (int c = 0; c < TW; c++)
                tpl_m[r * TW + c] = frame_pix((50 + r) * IMG_W + 100 + c);
        load_tpl();
        run_corr(100, 50, 1'b0, 0, 0, edges, corr, ok);
        first = (rd_q.size() > 0) ? rd_q[0] : -1;
        last  = (rd_q.size() > 0) ? rd_q[rd_q.size()-1] : -1;
        n_checks++; if (!ok || corr !== 14'd0) begin n_fail++; $display("FAIL match_corr: got %0d required 0", corr); end
        n_checks++; if (first != 32100) begin n_fail++; $display("FAIL match_first_addr: got %0d required 32100", first); end
        n_checks++; if (last != 36587) begin n_fail++; $display("FAIL match_last_addr: got %0d required 36587", last); end
    endtask

    task automatic test_max();
        int edges; logic [13:0] corr; bit ok;
        frame_mode = 0; frame_const = 0;
        for (int i = 0; i < N; i++) tpl_m[i] = 255;
        load_tpl();
        run_corr(17, 3, 1'b0, 0, 0, edges, corr, ok);
        n_checks++; if (!ok || corr !== 14'd16320) begin n_fail++; $display("FAIL max_corr: got %0d required 16320", corr); end
    endtask

    task automatic test_reject();
        int edges; logic [13:0] corr; bit ok; int last;
        run_corr(633, 0, 1'b0, 0, 0, edges, corr, ok);
        n_checks++; if (!ok || edges != 1) begin n_fail++; $display("FAIL rej_x_latency: got %0d edges required 1", edges); end
        n_checks++; if (rd_q.size() != 0) begin n_fail++; $display("FAIL rej_x_reads: got %0d required 0", rd_q.size()); end
        n_checks++; if (corr !== 14'h3FFF) begin n_fail++; $display("FAIL rej_x_corr: got %0d required 16383", corr); end
        @(negedge iCLK);
        n_checks++; if ({oBusy, oCorrFinished} !== 2'b00) begin n_fail++; $display("FAIL rej_after: busy,fin=%b required 00", {oBusy, oCorrFinished}); end
        run_corr(0, 473, 1'b0, 0, 0, edges, corr, ok);
        n_checks++; if (!ok || edges != 1 || rd_q.size() != 0) begin n_fail++; $display("FAIL rej_y: got %0d edges %0d reads required 1 and 0", edges, rd_q.size()); end
        // Exactly at the bottom-right corner the window is legal.
        frame_mode = 1; frame_seed = 77;
        run_corr(632, 472, 1'b0, 0, 0, edges, corr, ok);
        last = (rd_q.size() > 0) ? rd_q[rd_q.size()-1] : -1;
        n_checks++; if (!ok || edges != LAT) begin n_fail++; $display("FAIL corner_latency: got %0d required %0d", edges, LAT); end
        n_checks++; if (corr !== 14'(model_sad(632, 472))) begin n_fail++; $display("FAIL corner_corr: got %0d required %0d", corr, model_sad(632, 472)); end
        n_checks++; if (last != IMG_W * IMG_H - 1) begin n_fail++; $display("FAIL corner_last_addr: got %0d required %0d", last, IMG_W * IMG_H - 1); end
    endtask

    task automatic test_random();
        int edges; logic [13:0] corr; bit ok; int x, y, wa, wd, exp;
        for (int it = 0; it < 6; it++) begin
            frame_mode = 1; frame_seed = int'($urandom_range(0, 255));
            for (int i = 0; i < N; i++) tpl_m[i] = int'($urandom_range(0, 255));
            load_tpl();
            x = int'($urandom_range(0, IMG_W - TW));
            y = int'($urandom_range(0, IMG_H - TH));
            wa = int'($urandom_range(0, N - 1));
            wd = tpl_m[wa] ^ 255;
            // Odd iterations also write the template in the start cycle.
            if (it % 2 == 1) tpl_m[wa] = wd;
            exp = model_sad(x, y);
            run_corr(x, y, (it % 2 == 1), wa, wd, edges, corr, ok);
            n_checks++; if (!ok || edges != LAT) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d required %0d", it, edges, LAT); end
            n_checks++; if (corr !== 14'(exp)) begin n_fail++; $display("FAIL rand_corr[%0d]: got %0d required %0d at (%0d,%0d)", it, corr, exp, x, y); end
            n_checks++; if (addr_errors(x, y) != 0) begin n_fail++; $display("FAIL rand_addr_seq[%0d]: %0d wrong addresses, required 0", it, addr_errors(x, y)); end
        end
    endtask

    task automatic test_busy_ignored();
        int edges; logic [13:0] corr; bit ok; int exp, p0, w;
        frame_mode = 1; frame_seed = int'($urandom_range(0, 255));
        for (int i = 0; i < N; i++) tpl_m[i] = int'($urandom_range(0, 255));
        load_tpl();
        exp = model_sad(200, 100);
        rd_q.delete(); p0 = pulse_cnt;
        @(negedge iCLK); iStart = 1'b1; iX = 13'd200; iY = 13'd100;
        @(negedge iCLK); iStart = 1'b0;
        repeat (10) @(negedge iCLK);
        iStart = 1'b1; iX = 13'd8; iY = 13'd8;
        iTplWe = 1'b1; iTplAddr = 6'd0; iTplData = 8'(tpl_m[0] ^ 255);
        @(negedge iCLK); iStart = 1'b0; iTplWe = 1'b0;
        w = 0;
        while (!oCorrFinished && w < 200) begin @(negedge iCLK); w++; end
        n_checks++; if (w >= 200 || oCorr !== 14'(exp)) begin n_fail++; $display("FAIL busy_corr: got %0d required %0d", oCorr, exp); end
        n_checks++; if (rd_q.size() != N) begin n_fail++; $display("FAIL busy_nreads: got %0d required %0d", rd_q.size(), N); end
        repeat (100) @(negedge iCLK);
        n_checks++; if (pulse_cnt - p0 != 1) begin n_fail++; $display("FAIL busy_pulses: got %0d required 1", pulse_cnt - p0); end
        run_corr(200, 100, 1'b0, 0, 0, edges, corr, ok);
        n_checks++; if (!ok || corr !== 14'(exp)) begin n_fail++; $display("FAIL busy_tpl_kept: got %0d required %0d", corr, exp); end
    endtask

    task automatic test_reset_mid();
        int edges; logic [13:0] corr; bit ok; int p0, w;
        frame_mode = 1; frame_seed = int'($urandom_range(0, 255));
        rd_q.delete();
        @(negedge iCLK); iStart = 1'b1; iX = 13'd40; iY = 13'd30;
        @(negedge iCLK); iStart = 1'b0;
        w = 0;
        while (rd_q.size() < 30 && w < 100) begin @(negedge iCLK); w++; end
        #1 iRST_N = 1'b0;
        #1;
        n_checks++;
        if (w >= 100 || {oRdReq, oRdAddr, oBusy, oCorr, oCorrFinished} !== '0) begin
            n_fail++; $display("FAIL mid_reset_outputs: got %h required 0", {oRdReq, oRdAddr, oBusy, oCorr, oCorrFinished});
        end
        p0 = pulse_cnt;
        repeat (3) @(negedge iCLK);
        iRST_N = 1'b1;
        repeat (80) @(negedge iCLK);
        n_checks++; if (pulse_cnt != p0 || oCorr !== '0) begin n_fail++; $display("FAIL mid_reset_no_pulse: pulses %0d corr %0d required 0 and 0", pulse_cnt - p0, oCorr); end
        run_corr(40, 30, 1'b0, 0, 0, edges, corr, ok);
        n_checks++; if (!ok || edges != LAT || corr !== 14'(model_sad(40, 30))) begin
            n_fail++; $display("FAIL mid_reset_fresh: got %0d after %0d edges required %0d after %0d", corr, edges, model_sad(40, 30), LAT);
        end
    endtask

    task automatic test_back_to_back();
        int edges; logic [13:0] corr; bit ok;
        frame_mode = 1; frame_seed = int'($urandom_range(0, 255));
        run_corr(300, 200, 1'b0, 0, 0, edges, corr, ok);
        n_checks++; if (!ok || corr !== 14'(model_sad(300, 200))) begin n_fail++; $display("FAIL b2b_first: got %0d required %0d", corr, model_sad(300, 200)); end
        run_corr(5, 400, 1'b0, 0, 0, edges, corr, ok);
        n_checks++; if (!ok || edges != LAT) begin n_fail++; $display("FAIL b2b_latency: got %0d required %0d", edges, LAT); end
        n_checks++; if (corr !== 14'(model_sad(5, 400))) begin n_fail++; $display("FAIL b2b_second: got %0d required %0d", corr, model_sad(5, 400)); end
    endtask

    initial begin
        test_reset();
        test_const();
        test_match();
        test_max();
        test_reject();
        test_random();
        test_busy_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/window_correlator.md
# window_correlator

Computes the sum of absolute differences (SAD) between a stored TW×TH grayscale template and one TW×TH window of the captured frame. The window's top-left corner is given by the search controller's X/Y window position. The block reads frame pixels from the frame-buffer read port and returns a single correlation value with a completion pulse. It sits directly downstream of the search controller's oX/oY outputs and feeds that controller's iCurrentCorr/iCorrFinished inputs.

## Interface
- TW, 8, template width in pixels
- TH, 8, template height in pixels
- PIX_W, 8, grayscale pixel width
- IMG_W, 640, frame width in pixels
- IMG_H, 480, frame height in pixels
- ADDR_W, 19, frame-buffer address width
- RD_LAT, 2, fixed frame-buffer read latency in cycles (≥1)

Ports:
- iCLK  in  1  sole clock
- iRST_N  in  1  asynchronous, active-low reset
- iStart  in  1  request a correlation; sampled only in IDLE
- iX  in  13  window left column
- iY  in  13  window top row
- iTplWe  in  1  template write strobe
- iTplAddr  in  log2(TW*TH)  template index, row-major
- iTplData  in  PIX_W  template pixel
- oRdReq  out  1  frame-buffer read request
- oRdAddr  out  ADDR_W  frame-buffer address = row*IMG_W + col
- iRdData  in  PIX_W  read data, valid RD_LAT cycles after the request edge
- oBusy  out  1  high outside IDLE
- oCorr  out  SAD_W  last SAD result; SAD_W = PIX_W + log2(TW*TH), 14 at defaults
- oCorrFinished  out  1  one-cycle completion pulse

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE, REJECT.
- IDLE:
  - With iStart=1 and iX+TW ≤ IMG_W and iY+TH ≤ IMG_H: latch iX/iY, clear the accumulator, go to ISSUE.
  - With iStart=1 and the window out of bounds: go to REJECT.
- ISSUE: issue one read per cycle, N = TW*TH reads in row-major order (col fastest). Index k → address (Y+k/TW)*IMG_W + (X+k%TW). After the N-th read, go to DRAIN.
- Template index delay: the template index is delayed RD_LAT cycles alongside each request. When the delayed valid is set, acc += |iRdData − tpl[idx]|, computed in unsigned arithmetic with no saturation. The maximum sum fits in SAD_W bits exactly.
- DRAIN: wait until the last delayed valid has been accumulated, then go to DONE.
- DONE: oCorr ← acc, oCorrFinished=1 for one cycle, then IDLE.
- REJECT: oCorr ← all ones, oCorrFinished=1 for one cycle, no read issued, then IDLE.
- Template writes:
  - Applied at the edge only while oBusy=0. Writes during busy are dropped.
  - A write and a start in the same IDLE cycle: the write lands first, and the correlation uses the new value.
- iStart while busy is ignored. No queuing.
- iX/iY may change freely after the start edge.

## Timing
- Reset values: oRdReq=0, oRdAddr=0, oBusy=0, oCorr=0, oCorrFinished=0, FSM=IDLE, accumulator and delay line cleared. Template contents are not reset.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronously). No pulse is emitted, and in-flight read data is discarded.
- Accepted start at edge E0:
  - oRdReq is high for exactly N cycles, E0 through E(N−1).
  - oCorrFinished is high in the cycle after edge E(N+RD_LAT), i.e. a total latency of N+RD_LAT+1 edges (67 at defaults).
  - oBusy is high from E0 until the edge that ends DONE.
- Rejected start: oCorrFinished is high in the cycle after E0. oBusy is high only for that cycle.
- oCorr holds its value until the next DONE or REJECT.
- Earliest back-to-back start is in the cycle after oCorrFinished.

## Structure
- Package corr_pkg: TW, TH, PIX_W, N, SAD_W, TIDX_W, and the state enum {IDLE, ISSUE, DRAIN, DONE, REJECT}.
- Sub-module corr_tpl_ram: N×PIX_W register array with synchronous write and asynchronous read. It is indexed by the delayed template index.
- All other logic (FSM, address generator, RD_LAT delay line, abs-diff accumulator) lives in window_correlator.

## Test plan
- Template all 0, frame model all 10, start X=0 Y=0 → oCorr=640. Pulse 67 edges after start. 64 reads issued, first address 0, last address 4487.
- Template loaded from frame region (100,50), start X=100 Y=50 → oCorr=0. First address 32100, last address 36587.
- Template all 255, frame all 0 → oCorr=16320. No wrap.
- Start X=633 Y=0 → no oRdReq. oCorrFinished the next cycle. oCorr=16383.
- Second iStart and iTplWe during busy → both ignored. oCorr matches the first window and the template is unchanged.
- iRST_N pulsed at reading 30 of 64 → all outputs 0 immediately, no oCorrFinished. A fresh start afterwards gives the correct SAD.
